// File: rtl/pacman_tick_sequencer.sv
// Per-tick board RAM scheduler: Pac-Man first, then ghosts in order.
// Optional TICK_OVERRUN_EN adds a sticky tick_overrun output.
module pacman_tick_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int NUM_GHOSTS = 2,
  parameter int NUM_FOOD   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [ADDR_W-1:0]            pac_addr,
  input  logic [NUM_GHOSTS*ADDR_W-1:0] ghost_addr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [3:0]                   mem_wdata,
  input  logic [3:0]                   read_data,
  output logic                         pac_move,
  output logic [NUM_GHOSTS-1:0]        ghost_move,
  output logic                         food_eaten,
  output logic [8:0]                   food_left,
  output logic                         userWon,
  output logic                         busy,
  output logic                         round_done
`ifdef TICK_OVERRUN_EN
  ,
  output logic                         tick_overrun
`endif
);

  localparam int GW =
    (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam logic [GW-1:0] G_LAST =
    GW'(NUM_GHOSTS - 1);
  localparam logic [8:0] FOOD_INIT = 9'(NUM_FOOD);
  localparam logic [3:0] T_EMPTY   = 4'd0;
  localparam logic [3:0] T_WALL    = 4'd1;
  localparam logic [3:0] T_FOOD    = 4'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_PAC,
    EV_PAC,
    WR_PAC,
    RD_G,
    EV_G,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0]     pac_q;
  logic [ADDR_W-1:0]     ghost_q [NUM_GHOSTS];
  logic [GW-1:0]         g;
  logic                  pac_ok;
  logic [NUM_GHOSTS-1:0] ghost_ok;
  logic                  accept;
  logic                  not_wall;

  assign accept   = (state == IDLE) && tick && !userWon;
  assign not_wall = (read_data != T_WALL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RD_PAC;
      RD_PAC:  state_n = EV_PAC;
      EV_PAC:  state_n = (read_data == T_FOOD) ?
                         WR_PAC : RD_G;
      WR_PAC:  state_n = RD_G;
      RD_G:    state_n = EV_G;
      EV_G:    state_n = (g == G_LAST) ? DONE : RD_G;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs; forced idle while reset is held so an
  // aborted WR_PAC never reaches the RAM
  always_comb begin
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = T_EMPTY;
    food_eaten = 1'b0;
    pac_move   = 1'b0;
    ghost_move = '0;
    round_done = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      unique case (state)
        RD_PAC: mem_addr = pac_q;
        WR_PAC: begin
          mem_addr   = pac_q;
          mem_we     = 1'b1;
          food_eaten = 1'b1;
        end
        RD_G:   mem_addr = ghost_q[g];
        DONE: begin
          pac_move   = pac_ok;
          ghost_move = ghost_ok;
          round_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Latched targets, ghost index and move verdicts
  always_ff @(posedge clk) begin
    if (reset) begin
      pac_q    <= '0;
      for (int i = 0; i < NUM_GHOSTS; i++)
        ghost_q[i] <= '0;
      g        <= '0;
      pac_ok   <= 1'b0;
      ghost_ok <= '0;
    end else begin
      if (accept) begin
        pac_q <= pac_addr;
        for (int i = 0; i < NUM_GHOSTS; i++)
          ghost_q[i] <= ghost_addr[i*ADDR_W +: ADDR_W];
      end
      if (state == EV_PAC) begin
        pac_ok <= not_wall;
        g      <= '0;
      end
      if (state == EV_G) begin
        ghost_ok[g] <= not_wall;
        if (g != G_LAST) g <= g + 1'b1;
      end
    end
  end

  // Food counter (saturating) and sticky win flag
  always_ff @(posedge clk) begin
    if (reset) begin
      food_left <= FOOD_INIT;
      userWon   <= (NUM_FOOD == 0);
    end else if (state == WR_PAC) begin
      if (food_left != 9'd0)
        food_left <= food_left - 9'd1;
      if (food_left == 9'd1)
        userWon <= 1'b1;
    end
  end

`ifdef TICK_OVERRUN_EN
  // Sticky record of a tick dropped mid-round
  always_ff @(posedge clk) begin
    if (reset)
      tick_overrun <= 1'b0;
    else if (tick && state != IDLE && !userWon)
      tick_overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pacman_tick_sequencer.sv
// Directed bench for pacman_tick_sequencer.
// Carries its own board RAM model with one-cycle read latency.
module tb_pacman_tick_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [8:0]  pac_addr;
  logic [17:0] ghost_addr;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  read_data;
  logic        pac_move;
  logic [1:0]  ghost_move;
  logic        food_eaten;
  logic [8:0]  food_left;
  logic        userWon;
  logic        busy;
  logic        round_done;
`ifdef TICK_OVERRUN_EN
  logic        tick_overrun;
`endif

  int errors = 0;
  int checks = 0;
  int total_we = 0;

  logic [3:0] mem [512];

  pacman_tick_sequencer #(
    .ADDR_W(9), .NUM_GHOSTS(2), .NUM_FOOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .pac_addr(pac_addr),
    .ghost_addr(ghost_addr),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .read_data(read_data),
    .pac_move(pac_move),
    .ghost_move(ghost_move),
    .food_eaten(food_eaten),
    .food_left(food_left),
    .userWon(userWon),
    .busy(busy),
    .round_done(round_done)
`ifdef TICK_OVERRUN_EN
    ,
    .tick_overrun(tick_overrun)
`endif
  );

  always #5 clk = ~clk;

  // Board RAM: registered read, synchronous write
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      total_we++;
    end
    read_data <= mem[mem_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run one round from IDLE; targets are scrambled after
  // the accept cycle to prove they were latched.
  task automatic run_round(
    input  logic [8:0] pa,
    input  logic [8:0] g0,
    input  logic [8:0] g1,
    input  bit         extra,
    output int         dc,
    output logic       pm,
    output logic [1:0] gm,
    output int         nwe,
    output int         wc,
    output logic [8:0] wa,
    output logic [3:0] wd,
    output int         nfe);
    check("pre_idle", busy, 0);
    pac_addr   = pa;
    ghost_addr = {g1, g0};
    tick       = 1'b1;
    dc = -1; pm = 1'bx; gm = 2'bxx;
    nwe = 0; wc = -1; wa = '0; wd = '0; nfe = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tick       = 1'b0;
      pac_addr   = 9'd10;
      ghost_addr = {9'd10, 9'd10};
      if (extra && (c == 2 || c == 7)) tick = 1'b1;
`ifdef TICK_OVERRUN_EN
      if (extra && c == 2) check("ovr_c2", tick_overrun, 0);
      if (extra && c == 3) check("ovr_c3", tick_overrun, 1);
`endif
      if (mem_we) begin
        nwe++; wc = c; wa = mem_addr; wd = mem_wdata;
      end
      if (food_eaten) nfe++;
      if (round_done) begin
        dc = c; pm = pac_move; gm = ghost_move;
        break;
      end
    end
    @(negedge clk);
    tick = 1'b0;
    check("post_idle", busy, 0);
  endtask

  int         dc, nwe, wc, nfe, bad, we0;
  logic       pm;
  logic [1:0] gm;
  logic [8:0] wa;
  logic [3:0] wd;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 4'd0;
    mem[10] = 4'd1;
    for (int i = 20; i < 25; i++) mem[i] = 4'd2;
    mem[30] = 4'd3;
    reset = 1'b1; tick = 1'b0;
    pac_addr = '0; ghost_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_food", food_left, 5);
    check("rst_won", userWon, 0);
    check("rst_done", round_done, 0);
    check("rst_moves", {pac_move, ghost_move}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain round: empty / empty / passable tiles
    run_round(9'd0, 9'd0, 9'd30, 1'b0,
              dc, pm, gm, nwe, wc, wa, wd, nfe);
    check("r1_done", dc, 7);
    check("r1_pm", pm, 1);
    check("r1_gm", gm, 2'b11);
    check("r1_we", nwe, 0);
    check("r1_food", food_left, 5);

    // Walls, plus ticks at cycles 2 and 7
    run_round(9'd10, 9'd0, 9'd10, 1'b1,
              dc, pm, gm, nwe, wc, wa, wd, nfe);
    check("r2_done", dc, 7);
    check("r2_pm", pm, 0);
    check("r2_gm", gm, 2'b01);
    check("r2_we", nwe, 0);

    // Reset during WR_PAC aborts the write
    we0 = total_we;
    pac_addr = 9'd21; ghost_addr = '0; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_wr_state", mem_we, 1);
    reset = 1'b1;
    #1;
    check("ab_we_rst", mem_we, 0);
    check("ab_fe_rst", food_eaten, 0);
    @(negedge clk);
    reset = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_food", food_left, 5);
    check("ab_mem", mem[21], 2);
    check("ab_nowr", total_we - we0, 0);
`ifdef TICK_OVERRUN_EN
    check("ab_ovr", tick_overrun, 0);
`endif
    @(negedge clk);

    // First food round, checked in detail
    run_round(9'd20, 9'd0, 9'd0, 1'b0,
              dc, pm, gm, nwe, wc, wa, wd, nfe);
    check("f1_done", dc, 8);
    check("f1_wc", wc, 3);
    check("f1_nwe", nwe, 1);
    check("f1_wa", wa, 20);
    check("f1_wd", wd, 0);
    check("f1_fe", nfe, 1);
    check("f1_food", food_left, 4);
    check("f1_mem", mem[20], 0);
    check("f1_pm", pm, 1);

    // Remaining four food tiles
    for (int k = 21; k < 25; k++) begin
      check("fk_won_pre", userWon, 0);
      run_round(9'(k), 9'd30, 9'd0, 1'b0,
                dc, pm, gm, nwe, wc, wa, wd, nfe);
      check("fk_done", dc, 8);
      check("fk_food", food_left, 9'(24 - k));
    end
    check("win_flag", userWon, 1);
    check("win_food", food_left, 0);

    // Tick after win is ignored; no RAM traffic
    we0 = total_we;
    bad = 0;
    tick = 1'b1; pac_addr = 9'd30;
    @(negedge clk); tick = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy || mem_addr != 9'd0 || mem_we) bad++;
      @(negedge clk);
    end
    check("won_idle", bad, 0);
    check("won_nowr", total_we - we0, 0);
    check("won_sticky", userWon, 1);

    // Reset clears win and reloads the food count
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_won", userWon, 0);
    check("rst2_food", food_left, 5);
`ifdef TICK_OVERRUN_EN
    check("rst2_ovr", tick_overrun, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pacman_tick_sequencer.md
Name: pacman_tick_sequencer

Overview:
Per-game-tick controller that schedules all accesses to the single-port board tile RAM (4-bit tile codes: 0 empty, 1 wall, 2 food, 3+ passable).
- Serves Pac-Man first, then each ghost in index order.
- Reads each requester's target tile and grants or denies the move.
- Clears eaten food with a write-back and tracks food remaining.
- Asserts the win flag when no food remains.
- Sits between the movement logic (requesters) and the board RAM; it is the only RAM master during gameplay.

Parameters:
ADDR_W, 9, board tile address width
NUM_GHOSTS, 2, number of ghost requesters (1..4)
NUM_FOOD, 5, food tiles on the initial board (0..511)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tick  in  1  round start pulse
pac_addr  in  ADDR_W  Pac-Man proposed target tile, sampled on accepted tick
ghost_addr  in  NUM_GHOSTS*ADDR_W  ghost g target in bits [g*ADDR_W +: ADDR_W], sampled on accepted tick
mem_addr  out  ADDR_W  board RAM address
mem_we  out  1  board RAM write enable
mem_wdata  out  4  board RAM write data
read_data  in  4  board RAM read data, valid the cycle after a read address is presented
pac_move  out  1  high in DONE if Pac-Man target is not a wall
ghost_move  out  NUM_GHOSTS  bit g high in DONE if ghost g target is not a wall
food_eaten  out  1  one-cycle pulse in WR_PAC
food_left  out  9  food tiles remaining
userWon  out  1  sticky win flag
busy  out  1  high in every state except IDLE
round_done  out  1  one-cycle pulse in DONE

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. Reset has priority over all other activity.
- Reset values:
  - State = IDLE.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - pac_move, ghost_move, food_eaten, round_done, busy = 0.
  - food_left=NUM_FOOD.
  - userWon = (NUM_FOOD==0).
- Addresses are latched on tick acceptance; later changes on pac_addr/ghost_addr do not affect the round.
- FSM states: IDLE, RD_PAC, EV_PAC, WR_PAC, RD_G, EV_G, DONE.
- IDLE:
  - tick=1 and userWon=0 → latch addresses, go to RD_PAC.
  - Otherwise stay.
  - tick while busy or while userWon=1 is ignored.
- RD_PAC: mem_addr=latched pac_addr, mem_we=0 → EV_PAC.
- EV_PAC:
  - Record pac_ok = (read_data != 1).
  - read_data==2 → WR_PAC; else → RD_G with ghost index g=0.
- WR_PAC:
  - mem_addr=pac address, mem_we=1, mem_wdata=0.
  - food_eaten=1.
  - food_left decrements, saturating at 0.
  - If food_left was 1, userWon sets next cycle.
  - → RD_G with g=0.
- RD_G: mem_addr = ghost g latched address, read → EV_G.
- EV_G:
  - Record ghost_ok[g] = (read_data != 1). Ghosts never write and never eat food.
  - g<NUM_GHOSTS-1 → g++, RD_G; else → DONE.
- DONE:
  - pac_move=pac_ok, ghost_move=ghost_ok, round_done=1, all for exactly this cycle.
  - → IDLE.
- mem_we is high only in WR_PAC.
- Latency, tick accepted at cycle 0: RD_PAC at cycle 1.
  - DONE at cycle 3+2*NUM_GHOSTS without food.
  - DONE at cycle 4+2*NUM_GHOSTS with food.
  - NUM_GHOSTS=2 gives cycle 7 or 8.
- tick in the DONE cycle is ignored. The next accepted tick is the first tick seen in IDLE.
- userWon is sticky until reset. food_left never wraps below 0.
- Reset mid-round: abort immediately. A pending WR_PAC is not performed and no write occurs in the reset cycle. Outputs take their reset values.

Optional Feature:
Macro TICK_OVERRUN_EN.
- Defined: adds output port `tick_overrun` (1 bit).
  - Sticky flag, cleared only by reset.
  - Sets the cycle after tick=1 arrives while busy=1 and userWon=0.
- Undefined: the port does not exist; ignored ticks leave no trace.

Test Plan:
- Reset, tick with pac_addr tile=0, ghosts on tiles 0/0 → round_done at cycle 7, pac_move=1, ghost_move=2'b11, mem_we never high, food_left=5.
- Pac target tile=2 → WR_PAC at cycle 3 with mem_addr=pac_addr, mem_wdata=0, food_eaten pulse, food_left=4, round_done at cycle 8.
- Pac target=1 (wall), ghost1 target=1 → pac_move=0, ghost_move=2'b01, no write.
- Five food rounds (NUM_FOOD=5) → food_left=0 and userWon=1 after the 5th WR_PAC; a further tick leaves busy=0 and produces no RAM access.
- tick asserted at cycles 2 and 7 of a round → both ignored; with TICK_OVERRUN_EN, tick_overrun=1 from cycle 3; reset asserted at cycle 3 of a food round → no write, food_left=5, state IDLE.
